noise_frame_sequencer: RTL and testbench

- Controller that sequences a 32-bit Fibonacci LFSR noise datapath into stereo test-tone frames for the I2S transmit path.
- Captures a seed on start, loads the LFSR, then steps it on demand to fill left and right sample registers.
- Presents each frame on a valid/ready handshake, and stops after a programmed frame count or on request.
- Sits between the control/register logic and the I2S sample FIFO input.

---
 rtl/noise_seq_pkg.sv | 21 ++
 rtl/noise_lfsr.sv | 29 ++
 rtl/noise_frame_sequencer.sv | 125 ++++++++++++
 tb/tb_noise_frame_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/noise_seq_pkg.sv
// Shared definitions for the noise frame sequencer: FSM states, LFSR taps and
// the substitute seed used when software programs an all-zero seed.
package noise_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        GEN_L,
        GEN_R,
        PRESENT,
        DONE
    } seq_state_t;

    localparam int TAP_A = 31;
    localparam int TAP_B = 22;
    localparam int TAP_C = 1;
    localparam int TAP_D = 0;

    localparam int SAFE_SEED = 1;

endpackage

// File: rtl/noise_lfsr.sv
// Fibonacci LFSR register for the noise generator; a load wins over a step.
module noise_lfsr
    import noise_seq_pkg::*;
#(
    parameter int NBIT = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [NBIT-1:0] seed,
    output logic [NBIT-1:0] q
);

    logic feedback;

    assign feedback = q[TAP_A] ^ q[TAP_B] ^ q[TAP_C] ^ q[TAP_D];

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= seed;
        end else if (step) begin
            q <= {q[NBIT-2:0], feedback};
        end
    end

endmodule

// File: rtl/noise_frame_sequencer.sv
// Sequences LFSR noise into stereo (or duplicated mono) frames and offers them
// to the I2S sample FIFO over a valid/ready handshake.
module noise_frame_sequencer
    import noise_seq_pkg::*;
#(
    parameter int NBIT        = 32,
    parameter int SAMPLE_BITS = 24,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic [NBIT-1:0]        seed,
    input  logic [FRAME_CNT_W-1:0] frame_count,
    input  logic                   mono,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [SAMPLE_BITS-1:0] out_left,
    output logic [SAMPLE_BITS-1:0] out_right,
    output logic                   busy,
    output logic                   done,
    output logic [FRAME_CNT_W-1:0] frames_sent
);

    seq_state_t             state;
    logic [NBIT-1:0]        seed_r;
    logic [NBIT-1:0]        seed_eff;
    logic [FRAME_CNT_W-1:0] frame_cnt_r;
    logic [FRAME_CNT_W-1:0] frames_next;
    logic                   mono_r;
    logic                   stop_pend;
    logic                   last_frame;
    logic                   lfsr_load;
    logic                   lfsr_step;
    logic [NBIT-1:0]        lfsr_q;
    logic [SAMPLE_BITS-1:0] sample;

    assign seed_eff    = (seed == '0) ? NBIT'(SAFE_SEED) : seed;
    assign frames_next = frames_sent + FRAME_CNT_W'(1);
    assign last_frame  = (frame_cnt_r != '0) && (frames_next == frame_cnt_r);
    assign sample      = lfsr_q[SAMPLE_BITS-1:0];
    assign lfsr_load   = (state == SEED);
    assign lfsr_step   = (state == GEN_L) || ((state == GEN_R) && !mono_r);

    noise_lfsr #(
        .NBIT (NBIT)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .step (lfsr_step),
        .seed (seed_r),
        .q    (lfsr_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            out_left    <= '0;
            out_right   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frames_sent <= '0;
            stop_pend   <= 1'b0;
            frame_cnt_r <= '0;
            mono_r      <= 1'b0;
            seed_r      <= '0;
        end else begin
            done <= 1'b0;
            // A stop seen anywhere in a run is remembered until the frame boundary.
            if (state != IDLE && stop) begin
                stop_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        frame_cnt_r <= frame_count;
                        mono_r      <= mono;
                        seed_r      <= seed_eff;
                        frames_sent <= '0;
                        stop_pend   <= 1'b0;
                        busy        <= 1'b1;
                        state       <= SEED;
                    end
                end
                SEED: begin
                    state <= GEN_L;
                end
                GEN_L: begin
                    out_left <= sample;
                    state    <= GEN_R;
                end
                GEN_R: begin
                    out_right <= mono_r ? out_left : sample;
                    out_valid <= 1'b1;
                    state     <= PRESENT;
                end
                PRESENT: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        frames_sent <= frames_next;
                        if (last_frame || stop_pend || stop) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= GEN_L;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noise_frame_sequencer.sv
// Directed self-checking bench for noise_frame_sequencer: frame values, mono,
// stop, backpressure, start/stop corner cases and mid-run reset.
module tb_noise_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] seed = '0;
    logic [15:0] frame_count = '0;
    logic        mono = 1'b0;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [23:0] out_left;
    logic [23:0] out_right;
    logic        busy;
    logic        done;
    logic [15:0] frames_sent;

    int          assertCount = 0;
    int          failCount = 0;
    logic [31:0] modelQ;

    noise_frame_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .seed        (seed),
        .frame_count (frame_count),
        .mono        (mono),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_left    (out_left),
        .out_right   (out_right),
        .busy        (busy),
        .done        (done),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] lfsrStep(input logic [31:0] q);
        return {q[30:0], q[31] ^ q[22] ^ q[1] ^ q[0]};
    endfunction

    // Reference frame generator driven from modelQ.
    task automatic modelFrame(input logic isMono, output logic [23:0] l, output logic [23:0] r);
        l = modelQ[23:0];
        modelQ = lfsrStep(modelQ);
        if (isMono) begin
            r = l;
        end else begin
            r = modelQ[23:0];
            modelQ = lfsrStep(modelQ);
        end
    endtask

    // Pulse start for one cycle; returns at the negedge with the DUT in SEED.
    task automatic applyStimulus(input logic [31:0] s, input logic [15:0] cnt, input logic m);
        @(negedge clk);
        seed = s;
        frame_count = cnt;
        mono = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        modelQ = (s == 32'd0) ? 32'd1 : s;
    endtask

    // Wait for a frame, compare it, and step past the handshake edge.
    task automatic expectFrame(input string tag, input logic [23:0] l, input logic [23:0] r);
        int waited = 0;
        while (!out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!out_valid) begin
            checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            checkOutput({tag, "_left"}, {8'd0, out_left}, {8'd0, l});
            checkOutput({tag, "_right"}, {8'd0, out_right}, {8'd0, r});
            @(negedge clk);
        end
    endtask

    initial begin
        logic [23:0] l;
        logic [23:0] r;
        logic [23:0] heldL;
        logic [23:0] heldR;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_frames", {16'd0, frames_sent}, 32'd0);
        checkOutput("reset_left", {8'd0, out_left}, 32'd0);

        // Stereo, seed 1, two frames, start-to-valid latency of four edges.
        applyStimulus(32'd1, 16'd2, 1'b0);
        checkOutput("t1_busy_seed", {31'd0, busy}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t1_not_yet_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        checkOutput("t1_valid_at_n4", {31'd0, out_valid}, 32'd1);
        expectFrame("t1_f1", 24'h000001, 24'h000003);
        expectFrame("t1_f2", 24'h000006, 24'h00000D);
        checkOutput("t1_done", {31'd0, done}, 32'd1);
        checkOutput("t1_busy_in_done", {31'd0, busy}, 32'd1);
        @(negedge clk);
        checkOutput("t1_done_cleared", {31'd0, done}, 32'd0);
        checkOutput("t1_busy_low", {31'd0, busy}, 32'd0);
        checkOutput("t1_frames_sent", {16'd0, frames_sent}, 32'd2);

        // Mono with a zero seed substitutes 1.
        applyStimulus(32'd0, 16'd2, 1'b1);
        expectFrame("t2_f1", 24'h000001, 24'h000001);
        expectFrame("t2_f2", 24'h000003, 24'h000003);
        checkOutput("t2_done", {31'd0, done}, 32'd1);
        @(negedge clk);

        // Continuous run, stop pulsed during GEN_R of frame 5.
        applyStimulus(32'hACE1_2468, 16'd0, 1'b0);
        for (int f = 1; f <= 4; f++) begin
            modelFrame(1'b0, l, r);
            expectFrame($sformatf("t3_f%0d", f), l, r);
        end
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        modelFrame(1'b0, l, r);
        expectFrame("t3_f5", l, r);
        checkOutput("t3_done", {31'd0, done}, 32'd1);
        checkOutput("t3_frames_sent", {16'd0, frames_sent}, 32'd5);
        @(negedge clk);
        checkOutput("t3_idle", {31'd0, busy}, 32'd0);

        // Backpressure on frame 2 for ten cycles.
        applyStimulus(32'h1234_5678, 16'd3, 1'b0);
        modelFrame(1'b0, l, r);
        expectFrame("t4_f1", l, r);
        out_ready = 1'b0;
        modelFrame(1'b0, l, r);
        repeat (2) @(negedge clk);
        heldL = out_left;
        heldR = out_right;
        checkOutput("t4_stall_left", {8'd0, heldL}, {8'd0, l});
        checkOutput("t4_stall_right", {8'd0, heldR}, {8'd0, r});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("t4_stall_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("t4_stall_left_hold", {8'd0, out_left}, {8'd0, l});
            checkOutput("t4_stall_right_hold", {8'd0, out_right}, {8'd0, r});
        end
        out_ready = 1'b1;
        expectFrame("t4_f2", l, r);
        modelFrame(1'b0, l, r);
        expectFrame("t4_f3", l, r);
        checkOutput("t4_done", {31'd0, done}, 32'd1);
        checkOutput("t4_frames_sent", {16'd0, frames_sent}, 32'd3);
        @(negedge clk);

        // start together with stop in IDLE is refused.
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        checkOutput("t5_busy_refused", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("t5_still_idle", {31'd0, busy}, 32'd0);

        // start while busy must not disturb the run.
        applyStimulus(32'd1, 16'd2, 1'b0);
        @(negedge clk);
        seed = 32'h0000_FFFF;
        frame_count = 16'd5;
        mono = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        expectFrame("t5_f1", 24'h000001, 24'h000003);
        expectFrame("t5_f2", 24'h000006, 24'h00000D);
        checkOutput("t5_done", {31'd0, done}, 32'd1);
        checkOutput("t5_frames_sent", {16'd0, frames_sent}, 32'd2);
        @(negedge clk);

        // Reset in GEN_L of frame 3 aborts with no done pulse.
        applyStimulus(32'd1, 16'd0, 1'b0);
        expectFrame("t6_f1", 24'h000001, 24'h000003);
        expectFrame("t6_f2", 24'h000006, 24'h00000D);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("t6_busy", {31'd0, busy}, 32'd0);
        checkOutput("t6_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("t6_frames_sent", {16'd0, frames_sent}, 32'd0);
        checkOutput("t6_done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("t6_no_done_later", {31'd0, done}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
